// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Counts spikes per neuron channel over a programmable window of enabled
// cycles. At the end of each window it snapshots the counts and streams them
// out, one byte per channel and channel 0 first, over a valid/ready byte stream.
//
// Optional build macro SPIKE_DEC_HEADER_EN: when defined, each frame starts
// with a header byte {overrun, 3'b000, seq[3:0]}. seq is a 4-bit frame counter.
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active high
//   enable     update strobe; counting and window progress happen only while it is high
//   spike_in   spike vector, bit i = channel i
//   window_len window length in enabled cycles; 0 halts the decoder
//   out_data   stream byte
//   out_valid  out_data valid
//   out_ready  consumer accepts a byte when out_valid & out_ready
//   out_last   high with the final count byte of a frame
//   overrun    sticky; a window closed while a frame was still being sent
module spike_rate_decoder #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned WIN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] spike_in,
    input  logic [WIN_W-1:0]  window_len,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overrun
);

`ifdef SPIKE_DEC_HEADER_EN
    localparam int unsigned HDR_LEN = 1;
`else
    localparam int unsigned HDR_LEN = 0;
`endif
    localparam int unsigned FRAME_LEN = NUM_CH + HDR_LEN;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    logic [7:0]       live_q [NUM_CH];
    logic [7:0]       live_d [NUM_CH];
    logic [7:0]       live_inc [NUM_CH];
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] eff_len;
    logic             win_close;

    logic [7:0]       frame_q [FRAME_LEN];
    logic [7:0]       frame_d [FRAME_LEN];
    logic [7:0]       new_frame [FRAME_LEN];
    logic [IDX_W-1:0] idx_q, idx_d;
    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             ovr_q, ovr_d;
    logic             load;
    logic             fire;
`ifdef SPIKE_DEC_HEADER_EN
    logic [3:0]       seq_q, seq_d;
`endif

    // Live counters and window counter; window length is latched at counter 0
    always_comb begin
        eff_len   = (win_q == '0) ? window_len : len_q;
        win_close = 1'b0;
        win_d     = win_q;
        len_d     = len_q;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            // Saturating increment: a channel stuck at 255 stays there
            live_inc[ch] = (spike_in[ch] && live_q[ch] != 8'hFF) ? live_q[ch] + 8'(1) : live_q[ch];
            live_d[ch]   = live_q[ch];
        end
        if (enable && eff_len != '0) begin
            len_d = eff_len;
            if (win_q == eff_len - WIN_W'(1)) begin
                win_close = 1'b1;
                win_d     = '0;
                for (int unsigned ch = 0; ch < NUM_CH; ch++) live_d[ch] = 8'h00;
            end else begin
                win_d = win_q + WIN_W'(1);
                for (int unsigned ch = 0; ch < NUM_CH; ch++) live_d[ch] = live_inc[ch];
            end
        end
    end

    // Frame image captured on window close (includes the closing cycle's spikes)
    always_comb begin
`ifdef SPIKE_DEC_HEADER_EN
        new_frame[0] = {ovr_q, 3'b000, seq_q};
`endif
        for (int unsigned ch = 0; ch < NUM_CH; ch++) new_frame[ch + HDR_LEN] = live_inc[ch];
    end

    // Transmit FSM next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = ovr_q;
        load    = 1'b0;
        frame_d = frame_q;
`ifdef SPIKE_DEC_HEADER_EN
        seq_d   = seq_q;
`endif
        fire    = out_valid_q & out_ready;

        case (state_q)
            IDLE: begin
                if (win_close) begin
                    load    = 1'b1;
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (fire) begin
                    if (out_last_q) state_d = IDLE;
                    else            idx_d   = idx_q + IDX_W'(1);
                end
                // A close on the final handshake edge chains frames seamlessly
                if (win_close) begin
                    if (fire && out_last_q) begin
                        load    = 1'b1;
                        state_d = SEND;
                        idx_d   = '0;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            frame_d = new_frame;
`ifdef SPIKE_DEC_HEADER_EN
            seq_d   = seq_q + 4'(1);
`endif
        end

        out_valid_d = (state_d == SEND);
        out_data_d  = out_valid_d ? frame_d[idx_d] : 8'h00;
        out_last_d  = out_valid_d && (idx_d == IDX_W'(FRAME_LEN - 1));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) live_q[ch] <= 8'h00;
            for (int unsigned b = 0; b < FRAME_LEN; b++) frame_q[b] <= 8'h00;
            win_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'h00;
            ovr_q       <= 1'b0;
`ifdef SPIKE_DEC_HEADER_EN
            seq_q       <= 4'h0;
`endif
        end else begin
            live_q      <= live_d;
            frame_q     <= frame_d;
            win_q       <= win_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            ovr_q       <= ovr_d;
`ifdef SPIKE_DEC_HEADER_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: table-driven single-window vectors plus
// hand-written sequences for latency, backpressure, overrun, back-to-back
// frames and halt. Expected bytes go into a queue when stimulus is driven and
// are popped by a monitor as the stream handshakes.
module tb_spike_rate_decoder;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned WIN_W  = 10;
`ifdef SPIKE_DEC_HEADER_EN
    localparam int unsigned FRAME_LEN = NUM_CH + 1;
`else
    localparam int unsigned FRAME_LEN = NUM_CH;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] spike_in = '0;
    logic [WIN_W-1:0]  window_len = '0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              overrun;

    spike_rate_decoder #(.NUM_CH(NUM_CH), .WIN_W(WIN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [WIN_W-1:0] len;
        logic [2:0]       spk_en;
        logic [2:0]       spk_dis;
        bit               gap;
        logic [7:0]       e0;
        logic [7:0]       e1;
        logic [7:0]       e2;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        out_ready  = 1'b0;
        spike_in   = '0;
        window_len = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic push_frame(logic [7:0] hdr, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
        exp_t e;
`ifdef SPIKE_DEC_HEADER_EN
        e.data = hdr; e.last = 1'b0; q.push_back(e);
`else
        if (hdr != 8'h00) $display("note: header %0h ignored", hdr);
`endif
        e.data = b0; e.last = 1'b0; q.push_back(e);
        e.data = b1; e.last = 1'b0; q.push_back(e);
        e.data = b2; e.last = 1'b1; q.push_back(e);
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
        q.delete();
        step();
    endtask

    // Stream monitor: every handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected none", out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("byte_data", 32'(out_data), 32'(e.data));
                check("byte_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic run_vec(vec_t v);
        do_reset();
        window_len = v.len;
        out_ready  = 1'b1;
        push_frame(8'h00, v.e0, v.e1, v.e2);
        for (int i = 0; i < int'(v.len); i++) begin
            if (v.gap) begin
                enable   = 1'b0;
                spike_in = v.spk_dis;
                step();
            end
            enable   = 1'b1;
            spike_in = v.spk_en;
            step();
        end
        enable   = 1'b0;
        spike_in = '0;
        wait_drain("vec_drain", 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [7:0] first_byte;
        int n;

        vecs[0] = '{len: 10'd4,   spk_en: 3'b101, spk_dis: 3'b000, gap: 1'b0, e0: 8'd4,   e1: 8'd0,   e2: 8'd4};
        vecs[1] = '{len: 10'd300, spk_en: 3'b001, spk_dis: 3'b000, gap: 1'b0, e0: 8'd255, e1: 8'd0,   e2: 8'd0};
        vecs[2] = '{len: 10'd4,   spk_en: 3'b000, spk_dis: 3'b111, gap: 1'b1, e0: 8'd0,   e1: 8'd0,   e2: 8'd0};
        vecs[3] = '{len: 10'd1,   spk_en: 3'b010, spk_dis: 3'b000, gap: 1'b0, e0: 8'd0,   e1: 8'd1,   e2: 8'd0};
        vecs[4] = '{len: 10'd6,   spk_en: 3'b110, spk_dis: 3'b001, gap: 1'b1, e0: 8'd0,   e1: 8'd6,   e2: 8'd6};
        vecs[5] = '{len: 10'd255, spk_en: 3'b100, spk_dis: 3'b000, gap: 1'b0, e0: 8'd0,   e1: 8'd0,   e2: 8'd255};
        vecs[6] = '{len: 10'd256, spk_en: 3'b011, spk_dis: 3'b000, gap: 1'b0, e0: 8'd255, e1: 8'd255, e2: 8'd0};

        // Reset state
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Latency and backpressure
`ifdef SPIKE_DEC_HEADER_EN
        first_byte = 8'h00;
`else
        first_byte = 8'd4;
`endif
        do_reset();
        window_len = 10'd4;
        spike_in   = 3'b101;
        enable     = 1'b1;
        repeat (3) step();
        check("lat_before_close", 32'(out_valid), 32'd0);
        step();
        enable = 1'b0;
        check("lat_after_close", 32'(out_valid), 32'd1);
        check("lat_first_byte", 32'(out_data), 32'(first_byte));
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(first_byte));
            check("hold_last", 32'(out_last), 32'd0);
        end
        push_frame(8'h00, 8'd4, 8'd0, 8'd4);
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("one_per_cycle", 32'(n), 32'(FRAME_LEN));
        q.delete();
        step();
        check("idle_after_frame", 32'(out_valid), 32'd0);

        // Back-to-back frames: close coincides with last-byte handshake
        do_reset();
        window_len = 10'(FRAME_LEN);
        spike_in   = 3'b101;
        out_ready  = 1'b1;
        push_frame(8'h00, 8'(FRAME_LEN), 8'd0, 8'(FRAME_LEN));
        push_frame(8'h01, 8'(FRAME_LEN), 8'd0, 8'(FRAME_LEN));
        enable = 1'b1;
        repeat (2 * FRAME_LEN) step();
        enable = 1'b0;
        wait_drain("b2b_drain", 20);
        check("b2b_no_overrun", 32'(overrun), 32'd0);

        // Halt with window_len=0, then resume
        do_reset();
        out_ready = 1'b1;
        spike_in  = 3'b111;
        enable    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) check("halt_no_frame", 32'(out_valid), 32'd0);
        end
        check("halt_idle", 32'(out_valid), 32'd0);
        push_frame(8'h00, 8'd2, 8'd2, 8'd2);
        window_len = 10'd2;
        repeat (2) step();
        enable = 1'b0;
        wait_drain("resume_drain", 20);

        // Overrun, stickiness, header overrun bit, reset mid-frame
        do_reset();
        window_len = 10'd2;
        spike_in   = 3'b011;
        enable     = 1'b1;
        repeat (10) step();
        enable = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(out_valid), 32'd1);
`ifdef SPIKE_DEC_HEADER_EN
        check("ovr_first_byte", 32'(out_data), 32'h00);
`else
        check("ovr_first_byte", 32'(out_data), 32'd2);
`endif
        push_frame(8'h00, 8'd2, 8'd2, 8'd0);
        out_ready = 1'b1;
        wait_drain("ovr_drain", 20);
        check("ovr_sticky", 32'(overrun), 32'd1);
        out_ready = 1'b0;
        enable    = 1'b1;
        repeat (2) step();
        enable = 1'b0;
        check("ovr_next_valid", 32'(out_valid), 32'd1);
`ifdef SPIKE_DEC_HEADER_EN
        check("ovr_hdr", 32'(out_data), 32'h81);
`else
        check("ovr_next_data", 32'(out_data), 32'd2);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
